sound_scheduler: RTL and testbench
==================================

Name: sound_scheduler

Overview:
Sequences judgement sound events from the game logic (2-bit sound command: 0 Mute, 1 Perfect, 2 Good, 3 Miss) onto the single shared piezo output.
- Queues back-to-back events and plays each as a fixed-length square-wave tone followed by a silent gap.
- A Miss pre-empts a playing Perfect/Good tone.
- Sits between the game logic sound command output and the board piezo pin.

Parameters:
DUR_CYCLES, 5_000_000, tone length in clocks (100 ms at 50 MHz)
GAP_CYCLES, 500_000, silence between queued tones (10 ms)
DIV_PERFECT, 23_889, half-period in clocks for Perfect tone (~1046 Hz)
DIV_GOOD, 31_888, half-period for Good tone (~784 Hz)
DIV_MISS, 95_557, half-period for Miss tone (~262 Hz)
FIFO_DEPTH, 4, queued event capacity (power of two)

Ports:
i_Clk  in  1  system clock, 50 MHz
i_Rst  in  1  asynchronous, active-low reset
i_Sound_Cmd  in  2  per-cycle event code; nonzero value = one event in that cycle
i_Enable  in  1  sound enable switch; low = mute and flush
o_Piezo  out  1  square-wave drive to piezo
o_Active_Cmd  out  2  code of tone currently sounding; 0 when silent
o_Busy  out  1  high when state != IDLE or FIFO non-empty
o_Drop  out  1  one-cycle pulse when an event is discarded because the FIFO is full

Behaviour:
- Reset (async, i_Rst=0):
  - o_Piezo=0, o_Active_Cmd=0, o_Busy=0, o_Drop=0.
  - FIFO empty, state IDLE, all counters 0.
- FIFO:
  - Nonzero i_Sound_Cmd sampled at edge k is pushed at edge k if count < FIFO_DEPTH.
  - Otherwise the event is discarded and o_Drop=1 for the cycle after edge k.
  - A pop and a push on the same edge are both accepted, including when full.
  - Pointers wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits.
- States: IDLE, TONE, GAP.
- IDLE:
  - If FIFO non-empty: pop head, load half-period from code, clear counters, o_Piezo=0, go to TONE.
  - o_Active_Cmd = popped code from the same edge.
  - Latency: event in an empty, idle block at edge k is sounding (state TONE) after edge k+1.
- TONE:
  - Half-period counter 0..DIV-1; at DIV-1 toggle o_Piezo and clear.
  - Duration counter 0..DUR_CYCLES-1; at DUR_CYCLES-1: o_Piezo=0, o_Active_Cmd=0, go to GAP.
  - Tone occupies exactly DUR_CYCLES cycles.
- GAP:
  - o_Piezo held 0.
  - Counter 0..GAP_CYCLES-1, then go to IDLE.
  - A pending event pops on the following edge.
- Miss pre-emption:
  - Applies when i_Sound_Cmd=3 at an edge where state=TONE and o_Active_Cmd is 1 or 2.
  - FIFO flushed (count=0); the Miss is not enqueued.
  - Restart TONE with o_Active_Cmd=3, DIV_MISS, counters cleared, o_Piezo=0.
  - No o_Drop.
  - A Miss arriving in IDLE/GAP, or while a Miss sounds, is queued normally.
- Mute: i_Enable=0 at any edge →
  - state IDLE, FIFO flushed, counters cleared.
  - o_Piezo=0, o_Active_Cmd=0, o_Drop=0.
  - Inputs ignored while low.
  - Normal operation resumes the cycle i_Enable returns high.
- Simultaneous events:
  - Mute has priority over pre-emption, which has priority over push/pop.
  - A pop in IDLE and a push on the same edge: the push lands behind the popped entry.
- Reset asserted mid-tone: outputs go to reset values immediately (async); the queue is lost.
- Counters sized by $clog2 of their largest parameter; no other arithmetic.

Decomposition:
- Shared package rhythm_pkg:
  - sound codes SND_MUTE=0, SND_PERFECT=1, SND_GOOD=2, SND_MISS=3
  - scheduler state encoding (IDLE/TONE/GAP)
  - default tone half-period constants
- One sub-module sound_cmd_fifo:
  - synchronous push/pop/flush, count, full/empty
  - async active-low reset on i_Clk/i_Rst
- Tone/duration counters and FSM stay in the top.

Test Plan:
Sim overrides for all scenarios: DUR_CYCLES=20, GAP_CYCLES=4, DIV_PERFECT=2, DIV_GOOD=3, DIV_MISS=5, FIFO_DEPTH=4.
- Single event: reset, i_Enable=1, cmd=1 at edge 10 → o_Active_Cmd=1 after edge 11; o_Piezo toggles every 2 cycles for 20 cycles; then 4 silent cycles; o_Busy falls after GAP.
- Ordering: cmd 1,2,1 on consecutive edges → tones play in order 1,2,1, each 20 cycles with 4-cycle gaps; Good toggles every 3 cycles.
- Overflow: while a tone plays, push 5 events → 4 queued; 5th gives o_Drop=1 for exactly one cycle; FIFO pop/push same edge when full accepted without o_Drop.
- Pre-emption: cmd=1 playing with 2 queued, cmd=3 mid-tone → next cycle o_Active_Cmd=3, FIFO count 0, Miss lasts full 20 cycles, then idle.
- Mute: i_Enable=0 mid-tone with queue non-empty → next edge o_Piezo=0, o_Active_Cmd=0, o_Busy=0; events during mute ignored; re-enable and cmd=2 → plays normally.
- Async reset mid-tone: assert i_Rst=0 between clock edges → all outputs 0 immediately; after release, queue is empty and the first new event plays with 2-edge latency.

Source files
------------

// File: rtl/rhythm_pkg.sv
// Shared definitions for the rhythm game: sound command codes, scheduler
// state encoding and the default tone timing at a 50 MHz clock.
package rhythm_pkg;

    typedef enum logic [1:0] {
        SND_MUTE    = 2'd0,
        SND_PERFECT = 2'd1,
        SND_GOOD    = 2'd2,
        SND_MISS    = 2'd3
    } snd_code_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_t;

    localparam int DEF_DUR_CYCLES  = 5_000_000;
    localparam int DEF_GAP_CYCLES  = 500_000;
    localparam int DEF_DIV_PERFECT = 23_889;
    localparam int DEF_DIV_GOOD    = 31_888;
    localparam int DEF_DIV_MISS    = 95_557;
    localparam int DEF_FIFO_DEPTH  = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sound_cmd_fifo.sv
// Small queue of pending sound codes. A pop and a push on the same edge are
// both accepted even when full; flush empties the queue in one cycle.
module sound_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Flush,
    input  logic             i_Push,
    input  logic             i_Pop,
    input  logic [WIDTH-1:0] i_Data,
    output logic [WIDTH-1:0] o_Head,
    output logic             o_Full,
    output logic             o_Empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push_acc;
    logic             pop_acc;

    assign o_Full   = (count == CNT_W'(DEPTH));
    assign o_Empty  = (count == '0);
    assign pop_acc  = i_Pop && !o_Empty;
    assign push_acc = i_Push && (!o_Full || pop_acc);
    assign o_Head   = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, whatever order the simulator runs in.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (i_Flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
            if (push_acc && !pop_acc)      count <= count + 1'b1;
            else if (pop_acc && !push_acc) count <= count - 1'b1;
        end
    end

    // NOTE: the storage array has no reset; count guards every read, so
    // clearing it would only cost reset fan-out.
    always_ff @(posedge i_Clk) begin
        if (push_acc && !i_Flush) mem[wr_ptr] <= i_Data;
    end

endmodule

// File: rtl/sound_scheduler.sv
// Plays queued judgement sounds on the piezo as fixed-length square-wave
// tones separated by silent gaps; a Miss cuts short a Perfect/Good tone.
module sound_scheduler
    import rhythm_pkg::*;
#(
    parameter int DUR_CYCLES  = DEF_DUR_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int DIV_PERFECT = DEF_DIV_PERFECT,
    parameter int DIV_GOOD    = DEF_DIV_GOOD,
    parameter int DIV_MISS    = DEF_DIV_MISS,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [1:0] i_Sound_Cmd,
    input  logic       i_Enable,
    output logic       o_Piezo,
    output logic [1:0] o_Active_Cmd,
    output logic       o_Busy,
    output logic       o_Drop
);

    localparam int DUR_W  = (DUR_CYCLES > 1) ? $clog2(DUR_CYCLES) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int HALF_M = max3(DIV_PERFECT, DIV_GOOD, DIV_MISS);
    localparam int HALF_W = (HALF_M > 1) ? $clog2(HALF_M) : 1;

    localparam logic [DUR_W-1:0]  DUR_LAST  = DUR_W'(DUR_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [HALF_W-1:0] PERF_LAST = HALF_W'(DIV_PERFECT - 1);
    localparam logic [HALF_W-1:0] GOOD_LAST = HALF_W'(DIV_GOOD - 1);
    localparam logic [HALF_W-1:0] MISS_LAST = HALF_W'(DIV_MISS - 1);

    sched_state_t      state_q, state_d;
    snd_code_t         active_q, active_d;
    logic              piezo_q, piezo_d;
    logic              drop_q, drop_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic [HALF_W-1:0] half_last;

    logic       fifo_push, fifo_pop, fifo_flush;
    logic       fifo_full, fifo_empty;
    logic [1:0] fifo_head;
    logic       preempt;

    sound_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(2)) u_fifo (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Flush (fifo_flush),
        .i_Push  (fifo_push),
        .i_Pop   (fifo_pop),
        .i_Data  (i_Sound_Cmd),
        .o_Head  (fifo_head),
        .o_Full  (fifo_full),
        .o_Empty (fifo_empty)
    );

    always_comb begin
        case (active_q)
            SND_GOOD: half_last = GOOD_LAST;
            SND_MISS: half_last = MISS_LAST;
            default:  half_last = PERF_LAST;
        endcase
    end

    assign preempt = (state_q == ST_TONE) && (i_Sound_Cmd == SND_MISS) &&
                     ((active_q == SND_PERFECT) || (active_q == SND_GOOD));

    // NOTE: every output of this block is assigned a default first, so no
    // path through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        piezo_d    = piezo_q;
        dur_d      = dur_q;
        gap_d      = gap_q;
        half_d     = half_q;
        drop_d     = 1'b0;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        if (!i_Enable) begin
            state_d    = ST_IDLE;
            active_d   = SND_MUTE;
            piezo_d    = 1'b0;
            dur_d      = '0;
            gap_d      = '0;
            half_d     = '0;
            fifo_flush = 1'b1;
        end else if (preempt) begin
            state_d    = ST_TONE;
            active_d   = SND_MISS;
            piezo_d    = 1'b0;
            dur_d      = '0;
            half_d     = '0;
            fifo_flush = 1'b1;
        end else begin
            fifo_push = (i_Sound_Cmd != SND_MUTE);
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_TONE;
                        active_d = snd_code_t'(fifo_head);
                        piezo_d  = 1'b0;
                        dur_d    = '0;
                        half_d   = '0;
                    end
                end
                ST_TONE: begin
                    if (dur_q == DUR_LAST) begin
                        state_d  = ST_GAP;
                        active_d = SND_MUTE;
                        piezo_d  = 1'b0;
                        dur_d    = '0;
                        half_d   = '0;
                        gap_d    = '0;
                    end else begin
                        dur_d = dur_q + 1'b1;
                        if (half_q == half_last) begin
                            piezo_d = !piezo_q;
                            half_d  = '0;
                        end else begin
                            half_d = half_q + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    piezo_d = 1'b0;
                    if (gap_q == GAP_LAST) begin
                        state_d = ST_IDLE;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            // A same-edge pop frees the slot, so only a full, non-popping queue drops.
            drop_d = fifo_push && fifo_full && !fifo_pop;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q  <= ST_IDLE;
            active_q <= SND_MUTE;
            piezo_q  <= 1'b0;
            drop_q   <= 1'b0;
            dur_q    <= '0;
            gap_q    <= '0;
            half_q   <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            piezo_q  <= piezo_d;
            drop_q   <= drop_d;
            dur_q    <= dur_d;
            gap_q    <= gap_d;
            half_q   <= half_d;
        end
    end

    assign o_Piezo      = piezo_q;
    assign o_Active_Cmd = active_q;
    assign o_Drop       = drop_q;
    assign o_Busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_sound_scheduler.sv
// Directed bench for sound_scheduler with short sim timing; inputs change and
// outputs are sampled on the falling edge, away from the active rising edge.
module tb_sound_scheduler;

    localparam int DUR = 20;
    localparam int GAP = 4;
    localparam int DVP = 2;
    localparam int DVG = 3;
    localparam int DVM = 5;

    logic       clk;
    logic       rst_n;
    logic [1:0] cmd;
    logic       enable;
    logic       piezo;
    logic [1:0] active;
    logic       busy;
    logic       drop;

    int checks = 0;
    int errors = 0;

    sound_scheduler #(
        .DUR_CYCLES  (DUR),
        .GAP_CYCLES  (GAP),
        .DIV_PERFECT (DVP),
        .DIV_GOOD    (DVG),
        .DIV_MISS    (DVM),
        .FIFO_DEPTH  (4)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (rst_n),
        .i_Sound_Cmd  (cmd),
        .i_Enable     (enable),
        .o_Piezo      (piezo),
        .o_Active_Cmd (active),
        .o_Busy       (busy),
        .o_Drop       (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Checks tone cycles t0..DUR-1 of a tone with the given code and half-period.
    task automatic play_tone(input logic [1:0] code, input int div, input int t0, input string tag);
        for (int t = t0; t < DUR; t++) begin
            check($sformatf("%s_active_t%0d", tag, t), 32'(active), 32'(code));
            check($sformatf("%s_piezo_t%0d", tag, t), 32'(piezo), 32'((t / div) % 2));
            step();
        end
    endtask

    // Checks the gap cycles, then the single idle cycle that follows.
    task automatic gap_then_idle(input logic busy_in_idle, input string tag);
        for (int g = 0; g < GAP; g++) begin
            check($sformatf("%s_gap_active_%0d", tag, g), 32'(active), 32'd0);
            check($sformatf("%s_gap_piezo_%0d", tag, g), 32'(piezo), 32'd0);
            check($sformatf("%s_gap_busy_%0d", tag, g), 32'(busy), 32'd1);
            step();
        end
        check({tag, "_idle_active"}, 32'(active), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'(busy_in_idle));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        cmd    = 2'd0;
        repeat (3) step();
        check("rst_piezo", 32'(piezo), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (6) step();

        // Single Perfect event: queued after one edge, sounding after the next.
        cmd = 2'd1;
        step();
        cmd = 2'd0;
        check("single_queued_busy", 32'(busy), 32'd1);
        check("single_queued_active", 32'(active), 32'd0);
        step();
        play_tone(2'd1, DVP, 0, "single");
        gap_then_idle(1'b0, "single");
        step();

        // Ordering 1,2,1: the second push lands on the same edge as the first pop.
        cmd = 2'd1;
        step();
        cmd = 2'd2;
        step();
        cmd = 2'd1;
        check("order_first_active", 32'(active), 32'd1);
        step();
        cmd = 2'd0;
        play_tone(2'd1, DVP, 1, "order1");
        gap_then_idle(1'b1, "order1");
        step();
        play_tone(2'd2, DVG, 0, "order2");
        gap_then_idle(1'b1, "order2");
        step();
        play_tone(2'd1, DVP, 0, "order3");
        gap_then_idle(1'b0, "order3");
        step();

        // Overflow: four queued behind a playing tone, fifth is dropped.
        cmd = 2'd1;
        step();
        cmd = 2'd0;
        step();
        for (int i = 0; i < 4; i++) begin
            cmd = (i % 2 == 0) ? 2'd2 : 2'd1;
            step();
            check($sformatf("ovf_nodrop_%0d", i), 32'(drop), 32'd0);
        end
        cmd = 2'd2;
        step();
        cmd = 2'd0;
        check("ovf_drop_pulse", 32'(drop), 32'd1);
        step();
        check("ovf_drop_clear", 32'(drop), 32'd0);
        play_tone(2'd1, DVP, 6, "ovf0");
        gap_then_idle(1'b1, "ovf0");
        cmd = 2'd2;
        step();
        cmd = 2'd0;
        check("ovf_poppush_nodrop", 32'(drop), 32'd0);
        play_tone(2'd2, DVG, 0, "ovf1");
        gap_then_idle(1'b1, "ovf1");
        step();
        play_tone(2'd1, DVP, 0, "ovf2");
        gap_then_idle(1'b1, "ovf2");
        step();
        play_tone(2'd2, DVG, 0, "ovf3");
        gap_then_idle(1'b1, "ovf3");
        step();
        play_tone(2'd1, DVP, 0, "ovf4");
        gap_then_idle(1'b1, "ovf4");
        step();
        play_tone(2'd2, DVG, 0, "ovf5");
        gap_then_idle(1'b0, "ovf5");
        step();

        // Pre-emption: Miss during a Perfect with two Goods queued.
        cmd = 2'd1;
        step();
        cmd = 2'd2;
        step();
        cmd = 2'd2;
        step();
        cmd = 2'd0;
        step();
        check("pre_before_active", 32'(active), 32'd1);
        cmd = 2'd3;
        step();
        cmd = 2'd0;
        check("pre_nodrop", 32'(drop), 32'd0);
        play_tone(2'd3, DVM, 0, "pre");
        gap_then_idle(1'b0, "pre");
        step();

        // Mute mid-tone with a queued event, ignore input while muted, resume.
        cmd = 2'd1;
        step();
        cmd = 2'd2;
        step();
        cmd = 2'd0;
        step();
        step();
        check("mute_before_piezo", 32'(piezo), 32'd1);
        enable = 1'b0;
        cmd    = 2'd1;
        step();
        check("mute_piezo", 32'(piezo), 32'd0);
        check("mute_active", 32'(active), 32'd0);
        check("mute_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cmd = (i == 1) ? 2'd3 : 2'd1;
            step();
            check($sformatf("mute_ignored_busy_%0d", i), 32'(busy), 32'd0);
            check($sformatf("mute_ignored_drop_%0d", i), 32'(drop), 32'd0);
        end
        enable = 1'b1;
        cmd    = 2'd2;
        step();
        cmd = 2'd0;
        check("unmute_queued_busy", 32'(busy), 32'd1);
        check("unmute_queued_active", 32'(active), 32'd0);
        step();
        play_tone(2'd2, DVG, 0, "unmute");
        gap_then_idle(1'b0, "unmute");
        step();

        // Asynchronous reset between edges while a tone sounds and one is queued.
        cmd = 2'd1;
        step();
        cmd = 2'd2;
        step();
        cmd = 2'd0;
        step();
        step();
        check("areset_before_piezo", 32'(piezo), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("areset_piezo", 32'(piezo), 32'd0);
        check("areset_active", 32'(active), 32'd0);
        check("areset_busy", 32'(busy), 32'd0);
        check("areset_drop", 32'(drop), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("areset_queue_empty", 32'(busy), 32'd0);
        cmd = 2'd1;
        step();
        cmd = 2'd0;
        check("areset_latency_active", 32'(active), 32'd0);
        step();
        play_tone(2'd1, DVP, 0, "areset");
        gap_then_idle(1'b0, "areset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
